// File: rtl/detector_pkg.sv
// detector_pkg: shared FSM state encoding and default parameters for the detector timing block.
// Contents:
//   CNT_W_DEF     - default timing counter / cfg port width
//   ALIGN_DLY_DEF - default pixel-data pipeline latency
//   state_t       - frame FSM states
package detector_pkg;
    localparam int CNT_W_DEF     = 16;
    localparam int ALIGN_DLY_DEF = 2;
    typedef enum logic [2:0] {IDLE, INTEG, SETTLE, ACTIVE, HBLANK, DONE} state_t;
endpackage

// File: rtl/detector_delay.sv
// detector_delay: fixed-latency register pipeline aligning strobes with pixel data.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (clears the pipeline)
//   i_data     - DATA_WIDTH bits in
//   o_data     - i_data delayed DELAY_CYCLE (>=1) cycles
module detector_delay #(
    parameter int DATA_WIDTH  = 2,
    parameter int DELAY_CYCLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);
    logic [DATA_WIDTH-1:0] r_pipe [DELAY_CYCLE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY_CYCLE; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < DELAY_CYCLE; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_data = r_pipe[DELAY_CYCLE-1];
endmodule

// File: rtl/detector_timing_ctrl.sv
// detector_timing_ctrl: frame timing FSM (integrate, settle, line readout) for an image detector.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   i_cont_mode        - only with DETECTOR_TIMING_CTRL_CONT_EN: restart frames back to back
//   i_start, i_abort   - single-cycle frame request, terminate current frame
//   i_cfg_*            - integration, settle, pixels/line, blank/line, lines/frame (latched at start)
//   o_det_int, o_det_rd          - detector integration window, pixel read enable
//   o_line_valid, o_frame_valid  - read / readout-region strobes delayed ALIGN_DLY cycles
//   o_busy, o_frame_done         - not idle, one-cycle pulse at normal frame completion
// Build option: DETECTOR_TIMING_CTRL_CONT_EN enables continuous mode.
module detector_timing_ctrl
    import detector_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int ALIGN_DLY = ALIGN_DLY_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef DETECTOR_TIMING_CTRL_CONT_EN
    input  logic             i_cont_mode,
`endif
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_cfg_int_time,
    input  logic [CNT_W-1:0] i_cfg_settle,
    input  logic [CNT_W-1:0] i_cfg_h_active,
    input  logic [CNT_W-1:0] i_cfg_h_blank,
    input  logic [CNT_W-1:0] i_cfg_v_active,
    output logic             o_det_int,
    output logic             o_det_rd,
    output logic             o_line_valid,
    output logic             o_frame_valid,
    output logic             o_busy,
    output logic             o_frame_done
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt, r_line, r_settle, r_h_active, r_h_blank;
    logic             r_det_int, r_det_rd, r_fv_src, r_busy, r_frame_done;
    logic [CNT_W-1:0] w_int, w_h_active, w_v_active;
    logic [1:0]       w_aligned;
    logic             w_cont, w_launch;

`ifdef DETECTOR_TIMING_CTRL_CONT_EN
    assign w_cont = i_cont_mode;
`else
    assign w_cont = 1'b0;
`endif

    // Zero lengths that cannot be skipped are promoted to one cycle
    assign w_int      = (i_cfg_int_time == '0) ? ONE : i_cfg_int_time;
    assign w_h_active = (i_cfg_h_active == '0) ? ONE : i_cfg_h_active;
    assign w_v_active = (i_cfg_v_active == '0) ? ONE : i_cfg_v_active;
    // Start is only honoured in IDLE (abort beats it); DONE relaunches only in continuous mode
    assign w_launch   = ((r_state == IDLE) && i_start && !i_abort) || ((r_state == DONE) && w_cont);

    // r_cnt holds cycles left in the current state, r_line lines left; both stop at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_line       <= '0;
            r_settle     <= '0;
            r_h_active   <= '0;
            r_h_blank    <= '0;
            r_det_int    <= 1'b0;
            r_det_rd     <= 1'b0;
            r_fv_src     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (i_abort && r_state != IDLE) begin
            r_state      <= IDLE;
            r_det_int    <= 1'b0;
            r_det_rd     <= 1'b0;
            r_fv_src     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (w_launch) begin
            r_state      <= INTEG;
            r_cnt        <= w_int;
            r_line       <= w_v_active;
            r_settle     <= i_cfg_settle;
            r_h_active   <= w_h_active;
            r_h_blank    <= i_cfg_h_blank;
            r_det_int    <= 1'b1;
            r_det_rd     <= 1'b0;
            r_fv_src     <= 1'b0;
            r_busy       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                INTEG, SETTLE, HBLANK: begin
                    if (r_cnt != ONE) begin
                        r_cnt <= r_cnt - ONE;
                    end else if (r_state == INTEG && r_settle != '0) begin
                        r_state   <= SETTLE;
                        r_cnt     <= r_settle;
                        r_det_int <= 1'b0;
                    end else begin
                        r_state   <= ACTIVE;
                        r_cnt     <= r_h_active;
                        r_det_int <= 1'b0;
                        r_det_rd  <= 1'b1;
                        r_fv_src  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (r_cnt != ONE) begin
                        r_cnt <= r_cnt - ONE;
                    end else begin
                        r_line <= r_line - ONE;
                        if (r_line == ONE) begin
                            r_state      <= DONE;
                            r_det_rd     <= 1'b0;
                            r_fv_src     <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else if (r_h_blank != '0) begin
                            r_state  <= HBLANK;
                            r_cnt    <= r_h_blank;
                            r_det_rd <= 1'b0;
                        end else begin
                            r_cnt <= r_h_active;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    detector_delay #(
        .DATA_WIDTH (2),
        .DELAY_CYCLE(ALIGN_DLY)
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .i_data({r_fv_src, r_det_rd}),
        .o_data(w_aligned)
    );

    assign o_det_int     = r_det_int;
    assign o_det_rd      = r_det_rd;
    assign o_busy        = r_busy;
    assign o_frame_done  = r_frame_done;
    assign o_frame_valid = w_aligned[1];
    assign o_line_valid  = w_aligned[0];
endmodule

// File: tb/tb_detector_timing_ctrl.sv
// tb_detector_timing_ctrl: directed and random checks of detector_timing_ctrl against a frame-timeline model.
module tb_detector_timing_ctrl;
    localparam int CW = 16;
    localparam int AD = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [CW-1:0] i_cfg_int_time = '0;
    logic [CW-1:0] i_cfg_settle = '0;
    logic [CW-1:0] i_cfg_h_active = '0;
    logic [CW-1:0] i_cfg_h_blank = '0;
    logic [CW-1:0] i_cfg_v_active = '0;
    logic          o_det_int, o_det_rd, o_line_valid, o_frame_valid, o_busy, o_frame_done;

    int ncmp = 0, nerr = 0, cyc = 0, ndone = 0;
    int fs = -1, fe = 0;
    int m_i, m_s, m_a, m_b, m_v;
    int c_int = 0, c_set = 0, c_ha = 0, c_hb = 0, c_va = 0;
    bit hist_rd [0:4095];
    bit hist_fv [0:4095];

    always #5 clk = ~clk;

    detector_timing_ctrl #(.CNT_W(CW), .ALIGN_DLY(AD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef DETECTOR_TIMING_CTRL_CONT_EN
        .i_cont_mode   (1'b0),
`endif
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_cfg_int_time(i_cfg_int_time),
        .i_cfg_settle  (i_cfg_settle),
        .i_cfg_h_active(i_cfg_h_active),
        .i_cfg_h_blank (i_cfg_h_blank),
        .i_cfg_v_active(i_cfg_v_active),
        .o_det_int     (o_det_int),
        .o_det_rd      (o_det_rd),
        .o_line_valid  (o_line_valid),
        .o_frame_valid (o_frame_valid),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done)
    );

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc - 1, obs, exp);
        end
    endtask

    // Frame timeline from the rules: INTEG I, SETTLE S, then V lines of A read cycles
    // separated by B blank cycles (none after the last), then one DONE cycle.
    // Returns {det_int, det_rd, frame_valid source, busy, frame_done} for cycle c.
    function automatic logic [4:0] core(input int c);
        int t, r, rlen, flen;
        logic [4:0] v;
        v = '0;
        if (fs >= 0 && c > fs && c <= fe) begin
            t    = c - fs - 1;
            rlen = m_v * m_a + (m_v - 1) * m_b;
            flen = m_i + m_s + rlen + 1;
            r    = t - m_i - m_s;
            if (t < flen) begin
                v[1] = 1'b1;
                v[4] = (t < m_i);
                v[0] = (t == flen - 1);
                if (r >= 0 && r < rlen) begin
                    v[2] = 1'b1;
                    v[3] = ((r % (m_a + m_b)) < m_a);
                end
            end
        end
        return v;
    endfunction

    function automatic int one_min(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    // One clock cycle: check the current cycle's outputs, then drive inputs sampled at its end
    task automatic step(input logic st, input logic ab);
        logic [4:0] m;
        logic lv, fv;
        @(negedge clk);
        m = core(cyc);
        hist_rd[cyc] = m[3];
        hist_fv[cyc] = m[2];
        lv = (cyc >= AD) ? hist_rd[cyc-AD] : 1'b0;
        fv = (cyc >= AD) ? hist_fv[cyc-AD] : 1'b0;
        cyc++;
        chk("cycle", {o_det_int, o_det_rd, o_line_valid, o_frame_valid, o_busy, o_frame_done},
            {m[4], m[3], lv, fv, m[1], m[0]});
        if (o_frame_done === 1'b1) ndone++;
        i_start        = st;
        i_abort        = ab;
        i_cfg_int_time = CW'(c_int);
        i_cfg_settle   = CW'(c_set);
        i_cfg_h_active = CW'(c_ha);
        i_cfg_h_blank  = CW'(c_hb);
        i_cfg_v_active = CW'(c_va);
        if (m[1]) begin
            if (ab) fe = cyc - 1;
        end else if (st && !ab) begin
            fs  = cyc - 1;
            fe  = 1 << 30;
            m_i = one_min(c_int);
            m_s = c_set;
            m_a = one_min(c_ha);
            m_b = c_hb;
            m_v = one_min(c_va);
        end
    endtask

    task automatic idle_to(input int k);
        while (cyc < k) step(1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", {o_det_int, o_det_rd, o_line_valid, o_frame_valid, o_busy, o_frame_done}, 6'd0);
        rst_n = 1'b1;
        // Reference frame: int=3 settle=2 h_active=4 h_blank=2 v_active=2, start at 10, extra starts at 15, 26
        c_int = 3; c_set = 2; c_ha = 4; c_hb = 2; c_va = 2;
        idle_to(10);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("det_int_c11", 6'(o_det_int), 6'd1);
        idle_to(14);
        chk("det_int_c13", 6'(o_det_int), 6'd1);
        step(1'b0, 1'b0);
        chk("det_int_c14", 6'(o_det_int), 6'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("det_rd_c16", 6'(o_det_rd), 6'd1);
        chk("line_valid_c16", 6'(o_line_valid), 6'd0);
        idle_to(20);
        chk("line_valid_c19", 6'(o_line_valid), 6'd1);
        step(1'b0, 1'b0);
        chk("det_rd_c20", 6'(o_det_rd), 6'd0);
        chk("frame_valid_c20", 6'(o_frame_valid), 6'd1);
        idle_to(26);
        chk("det_rd_c25", 6'(o_det_rd), 6'd1);
        step(1'b1, 1'b0);
        chk("frame_done_c26", 6'(o_frame_done), 6'd1);
        step(1'b0, 1'b0);
        chk("busy_c27", 6'(o_busy), 6'd0);
        chk("line_valid_c27", 6'(o_line_valid), 6'd1);
        step(1'b0, 1'b0);
        chk("frame_valid_c28", 6'(o_frame_valid), 6'd0);
        idle_to(40);
        chk("single_frame", 6'(ndone), 6'd1);
        chk("busy_c39", 6'(o_busy), 6'd0);
        // Abort during the first line
        step(1'b1, 1'b0);
        idle_to(47);
        step(1'b0, 1'b1);
        chk("det_rd_c47", 6'(o_det_rd), 6'd1);
        step(1'b0, 1'b0);
        chk("abort_det_rd", 6'(o_det_rd), 6'd0);
        chk("abort_busy", 6'(o_busy), 6'd0);
        step(1'b0, 1'b0);
        chk("abort_lv_drain", 6'(o_line_valid), 6'd1);
        step(1'b0, 1'b0);
        chk("abort_lv_fall", 6'(o_line_valid), 6'd0);
        idle_to(60);
        chk("abort_no_done", 6'(ndone), 6'd1);
        // All-zero configuration
        c_int = 0; c_set = 0; c_ha = 0; c_hb = 0; c_va = 0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("zero_det_int", 6'(o_det_int), 6'd1);
        step(1'b0, 1'b0);
        chk("zero_det_rd", 6'({o_det_int, o_det_rd}), 6'd1);
        step(1'b0, 1'b0);
        chk("zero_frame_done", 6'(o_frame_done), 6'd1);
        step(1'b0, 1'b0);
        chk("zero_busy_low", 6'(o_busy), 6'd0);
        chk("zero_done_count", 6'(ndone), 6'd2);
        // Abort and start in the same idle cycle
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("abort_beats_start", 6'(o_busy), 6'd0);
        // Asynchronous reset 20 cycles into a frame
        c_int = 5; c_set = 3; c_ha = 6; c_hb = 3; c_va = 4;
        idle_to(70);
        step(1'b1, 1'b0);
        idle_to(91);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {o_det_int, o_det_rd, o_line_valid, o_frame_valid, o_busy, o_frame_done}, 6'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc += 2;
        fs = -1;
        for (int k = cyc - 5; k < cyc; k++) begin
            hist_rd[k] = 1'b0;
            hist_fv[k] = 1'b0;
        end
        step(1'b1, 1'b0);
        idle_to(cyc + 45);
        chk("frame_after_reset", 6'(ndone), 6'd3);
        // Random traffic: cfg changes every cycle, sporadic starts and aborts
        for (int k = 0; k < 2000; k++) begin
            c_int = $urandom_range(0, 4);
            c_set = $urandom_range(0, 3);
            c_ha  = $urandom_range(0, 4);
            c_hb  = $urandom_range(0, 3);
            c_va  = $urandom_range(0, 3);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
        end
        step(1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
